// File: rtl/kem_op_sched.sv
// Top-level KEM operation scheduler: arbitrates one of three micro-op sequencers
// (keygen/encaps/decaps) onto the single kyber_top command port, with a per-command watchdog.
module kem_op_sched #(
    parameter int WDOG_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_start,
    input  logic [1:0]  op_sel,
    input  logic        clear,
    output logic        op_busy,
    output logic        op_done,
    output logic        op_err,
    output logic [1:0]  err_code,
    output logic [7:0]  op_count,
    output logic [2:0]  seq_start,
    input  logic [2:0]  seq_done,
    input  logic [11:0] seq_cmd_op,
    input  logic [14:0] seq_cmd_slot_a,
    input  logic [14:0] seq_cmd_slot_b,
    input  logic [11:0] seq_cmd_param,
    input  logic [2:0]  seq_cmd_start,
    output logic [2:0]  seq_cmd_done,
    output logic [3:0]  cmd_op,
    output logic [4:0]  cmd_slot_a,
    output logic [4:0]  cmd_slot_b,
    output logic [3:0]  cmd_param,
    output logic        cmd_start,
    input  logic        cmd_done
);

    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

    state_t          state_q;
    logic [1:0]      owner_q;
    logic            pending_q;
    logic [WW-1:0]   wdog_q;
    logic            op_done_q, op_err_q;
    logic [1:0]      err_code_q;
    logic [7:0]      op_count_q;
    logic [2:0]      seq_start_q;
    logic [3:0]      cmd_op_q, cmd_param_q;
    logic [4:0]      cmd_slot_a_q, cmd_slot_b_q;
    logic            cmd_start_q;

    logic [3:0]      own_op, own_param;
    logic [4:0]      own_a, own_b;
    logic            own_start, own_done;
    logic            wdog_expire;

    always_comb begin
        own_op    = '0;
        own_param = '0;
        own_a     = '0;
        own_b     = '0;
        own_start = 1'b0;
        own_done  = 1'b0;
        case (owner_q)
            2'd0: begin
                own_op = seq_cmd_op[3:0];     own_param = seq_cmd_param[3:0];
                own_a  = seq_cmd_slot_a[4:0]; own_b     = seq_cmd_slot_b[4:0];
                own_start = seq_cmd_start[0]; own_done  = seq_done[0];
            end
            2'd1: begin
                own_op = seq_cmd_op[7:4];     own_param = seq_cmd_param[7:4];
                own_a  = seq_cmd_slot_a[9:5]; own_b     = seq_cmd_slot_b[9:5];
                own_start = seq_cmd_start[1]; own_done  = seq_done[1];
            end
            2'd2: begin
                own_op = seq_cmd_op[11:8];      own_param = seq_cmd_param[11:8];
                own_a  = seq_cmd_slot_a[14:10]; own_b     = seq_cmd_slot_b[14:10];
                own_start = seq_cmd_start[2];   own_done  = seq_done[2];
            end
            default: ;
        endcase
    end

    // A fresh strobe or a completing cmd_done both pre-empt expiry in the same cycle.
    assign wdog_expire = pending_q && !own_start && !cmd_done && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            pending_q    <= 1'b0;
            wdog_q       <= '0;
            op_done_q    <= 1'b0;
            op_err_q     <= 1'b0;
            err_code_q   <= '0;
            op_count_q   <= '0;
            seq_start_q  <= '0;
            cmd_op_q     <= '0;
            cmd_param_q  <= '0;
            cmd_slot_a_q <= '0;
            cmd_slot_b_q <= '0;
            cmd_start_q  <= 1'b0;
        end else begin
            seq_start_q <= '0;
            op_done_q   <= 1'b0;
            op_err_q    <= 1'b0;
            cmd_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        if (op_sel == 2'd3) begin
                            op_err_q   <= 1'b1;
                            err_code_q <= 2'd1;
                        end else begin
                            owner_q     <= op_sel;
                            op_count_q  <= '0;
                            seq_start_q <= 3'b001 << op_sel;
                            pending_q   <= 1'b0;
                            wdog_q      <= '0;
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    cmd_op_q     <= own_op;
                    cmd_param_q  <= own_param;
                    cmd_slot_a_q <= own_a;
                    cmd_slot_b_q <= own_b;
                    cmd_start_q  <= own_start;
                    if (op_start) begin
                        op_err_q   <= 1'b1;
                        err_code_q <= 2'd2;
                    end
                    if (own_start) begin
                        pending_q <= 1'b1;
                        wdog_q    <= '0;
                        if (op_count_q != 8'hFF) op_count_q <= op_count_q + 8'd1;
                    end else if (cmd_done && pending_q) begin
                        pending_q <= 1'b0;
                        wdog_q    <= '0;
                    end else if (pending_q && !wdog_expire) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                    if (wdog_expire) begin
                        state_q    <= FAULT;
                        pending_q  <= 1'b0;
                        wdog_q     <= '0;
                        op_err_q   <= 1'b1;
                        err_code_q <= 2'd3;
                    end else if (own_done) begin
                        state_q   <= DONE;
                        op_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (op_start) begin
                        op_err_q   <= 1'b1;
                        err_code_q <= 2'd2;
                    end
                    pending_q <= 1'b0;
                    wdog_q    <= '0;
                    state_q   <= IDLE;
                end
                FAULT: begin
                    if (op_start) begin
                        op_err_q   <= 1'b1;
                        err_code_q <= 2'd2;
                    end
                    if (clear) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_busy      = (state_q != IDLE);
    assign op_done      = op_done_q;
    assign op_err       = op_err_q;
    assign err_code     = err_code_q;
    assign op_count     = op_count_q;
    assign seq_start    = seq_start_q;
    assign cmd_op       = cmd_op_q;
    assign cmd_slot_a   = cmd_slot_a_q;
    assign cmd_slot_b   = cmd_slot_b_q;
    assign cmd_param    = cmd_param_q;
    assign cmd_start    = cmd_start_q;
    assign seq_cmd_done = (state_q == RUN && owner_q != 2'd3) ? ({2'b00, cmd_done} << owner_q) : 3'b000;

endmodule

// File: tb/tb_kem_op_sched.sv
// Directed bench for kem_op_sched: a kyber_top responder answers each command
// three cycles later; each task plays one scenario and checks inline.
module tb_kem_op_sched;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        op_start = 1'b0, clear = 1'b0;
    logic [1:0]  op_sel = 2'd0;
    logic        op_busy, op_done, op_err;
    logic [1:0]  err_code;
    logic [7:0]  op_count;
    logic [2:0]  seq_start, seq_cmd_done;
    logic [2:0]  seq_done = '0, seq_cmd_start = '0;
    logic [11:0] seq_cmd_op = '0, seq_cmd_param = '0;
    logic [14:0] seq_cmd_slot_a = '0, seq_cmd_slot_b = '0;
    logic [3:0]  cmd_op, cmd_param;
    logic [4:0]  cmd_slot_a, cmd_slot_b;
    logic        cmd_start, cmd_done;
    logic        auto_done = 1'b0, man_done = 1'b0;
    bit          resp_en = 1'b1;
    int          rcnt = 0;
    int          n_cmp = 0, n_bad = 0, done_cnt = 0;

    assign cmd_done = auto_done | man_done;

    kem_op_sched #(.WDOG_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .op_sel(op_sel), .clear(clear),
        .op_busy(op_busy), .op_done(op_done), .op_err(op_err), .err_code(err_code),
        .op_count(op_count), .seq_start(seq_start), .seq_done(seq_done),
        .seq_cmd_op(seq_cmd_op), .seq_cmd_slot_a(seq_cmd_slot_a), .seq_cmd_slot_b(seq_cmd_slot_b),
        .seq_cmd_param(seq_cmd_param), .seq_cmd_start(seq_cmd_start), .seq_cmd_done(seq_cmd_done),
        .cmd_op(cmd_op), .cmd_slot_a(cmd_slot_a), .cmd_slot_b(cmd_slot_b), .cmd_param(cmd_param),
        .cmd_start(cmd_start), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (op_done) done_cnt++;

    // kyber_top model: cmd_done one cycle wide, three cycles after cmd_start is seen
    initial forever begin
        @(posedge clk);
        #2;
        auto_done = 1'b0;
        if (!rst_n || !resp_en) rcnt = 0;
        else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) auto_done = 1'b1;
        end else if (cmd_start) rcnt = 3;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic start_op(input logic [1:0] sel);
        @(negedge clk); op_start = 1'b1; op_sel = sel;
        @(negedge clk); op_start = 1'b0;
    endtask

    task automatic wait_cmd_done(input int idx, input string name);
        int w = 0;
        while (!seq_cmd_done[idx] && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (w >= 20) begin n_bad++; $display("FAIL %s: seq_cmd_done[%0d] never seen, required within 20 cycles", name, idx); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        seq_cmd_start = 3'b111; op_start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({op_busy, op_done, op_err, err_code, op_count, seq_start, seq_cmd_done, cmd_op,
             cmd_slot_a, cmd_slot_b, cmd_param, cmd_start} !== 38'd0) begin
            n_bad++; $display("FAIL reset_outputs: busy=%b start=%b seq_start=%b count=%0d, required all 0",
                              op_busy, cmd_start, seq_start, op_count);
        end
        seq_cmd_start = '0; op_start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (op_busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: busy=%b required 0", op_busy); end
    endtask

    task automatic test_keygen();
        int d0 = done_cnt;
        int fwd_bad = 0;
        seq_cmd_op = 12'hFF0; seq_cmd_param = 12'hFF0;
        seq_cmd_slot_a = 15'h7FE0; seq_cmd_slot_b = 15'h7FE0;
        start_op(2'd0);
        n_cmp++;
        if ({seq_start, op_busy} !== 4'b0011) begin n_bad++; $display("FAIL keygen_seq_start: seq_start=%b busy=%b required 001/1", seq_start, op_busy); end
        @(negedge clk);
        n_cmp++;
        if (seq_start !== 3'b000) begin n_bad++; $display("FAIL keygen_seq_start_width: seq_start=%b required 000", seq_start); end
        for (int i = 0; i < 69; i++) begin
            automatic logic [7:0] iv = i[7:0];
            seq_cmd_op[3:0] = iv[3:0]; seq_cmd_slot_a[4:0] = iv[4:0];
            seq_cmd_slot_b[4:0] = ~iv[4:0]; seq_cmd_param[3:0] = iv[7:4];
            seq_cmd_start = 3'b001;
            @(negedge clk);
            seq_cmd_start = 3'b000;
            n_cmp++;
            if ({cmd_start, cmd_op, cmd_slot_a, cmd_slot_b, cmd_param} !== {1'b1, iv[3:0], iv[4:0], ~iv[4:0], iv[7:4]}) begin
                n_bad++; fwd_bad++;
                if (fwd_bad < 4) $display("FAIL keygen_fwd_%0d: start=%b op=%h a=%h b=%h p=%h required 1/%h/%h/%h/%h", i,
                                          cmd_start, cmd_op, cmd_slot_a, cmd_slot_b, cmd_param, iv[3:0], iv[4:0], ~iv[4:0], iv[7:4]);
            end
            wait_cmd_done(0, "keygen_cmd_done");
        end
        seq_done = 3'b001;
        @(negedge clk); seq_done = 3'b000;
        n_cmp++;
        if ({op_done, op_busy, op_count} !== {1'b1, 1'b1, 8'd69}) begin
            n_bad++; $display("FAIL keygen_done: done=%b busy=%b count=%0d required 1/1/69", op_done, op_busy, op_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({op_done, op_busy, op_count, done_cnt - d0} !== {1'b0, 1'b0, 8'd69, 32'd1}) begin
            n_bad++; $display("FAIL keygen_idle: done=%b busy=%b count=%0d pulses=%0d required 0/0/69/1",
                              op_done, op_busy, op_count, done_cnt - d0);
        end
    endtask

    task automatic test_bad_sel();
        start_op(2'd3);
        n_cmp++;
        if ({op_err, err_code, op_busy, seq_start} !== {1'b1, 2'd1, 1'b0, 3'b000}) begin
            n_bad++; $display("FAIL bad_sel_err: err=%b code=%0d busy=%b seq_start=%b required 1/1/0/000", op_err, err_code, op_busy, seq_start);
        end
        @(negedge clk);
        n_cmp++;
        if ({op_err, err_code, op_busy} !== {1'b0, 2'd1, 1'b0}) begin
            n_bad++; $display("FAIL bad_sel_pulse: err=%b code=%0d busy=%b required 0/1/0", op_err, err_code, op_busy);
        end
    endtask

    task automatic test_busy_start();
        seq_cmd_op = 12'h5A5; seq_cmd_slot_a = 15'h0000; seq_cmd_slot_b = 15'h0000; seq_cmd_param = 12'h000;
        start_op(2'd1);
        n_cmp++;
        if (seq_start !== 3'b010) begin n_bad++; $display("FAIL encaps_seq_start: seq_start=%b required 010", seq_start); end
        seq_cmd_start = 3'b010;
        @(negedge clk); seq_cmd_start = 3'b000;
        n_cmp++;
        if ({cmd_start, cmd_op} !== 5'b1_1010) begin n_bad++; $display("FAIL encaps_fwd1: start=%b op=%h required 1/a", cmd_start, cmd_op); end
        op_start = 1'b1; op_sel = 2'd0;
        @(negedge clk); op_start = 1'b0;
        n_cmp++;
        if ({op_err, err_code, op_busy, seq_start} !== {1'b1, 2'd2, 1'b1, 3'b000}) begin
            n_bad++; $display("FAIL busy_start_err: err=%b code=%0d busy=%b seq_start=%b required 1/2/1/000", op_err, err_code, op_busy, seq_start);
        end
        wait_cmd_done(1, "encaps_cmd_done1");
        seq_cmd_op = 12'h5B5; seq_cmd_start = 3'b010;
        @(negedge clk); seq_cmd_start = 3'b000;
        n_cmp++;
        if ({cmd_start, cmd_op} !== 5'b1_1011) begin n_bad++; $display("FAIL encaps_owner_kept: start=%b op=%h required 1/b", cmd_start, cmd_op); end
        wait_cmd_done(1, "encaps_cmd_done2");
        seq_done = 3'b010;
        @(negedge clk); seq_done = 3'b000;
        n_cmp++;
        if ({op_done, op_count} !== {1'b1, 8'd2}) begin n_bad++; $display("FAIL encaps_done: done=%b count=%0d required 1/2", op_done, op_count); end
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        resp_en = 1'b0;
        start_op(2'd0);
        seq_cmd_start = 3'b001;
        @(negedge clk); seq_cmd_start = 3'b000;
        repeat (15) @(negedge clk);
        n_cmp++;
        if ({op_err, op_busy} !== 2'b01) begin n_bad++; $display("FAIL wdog_early: err=%b busy=%b required 0/1 after 15 cycles", op_err, op_busy); end
        @(negedge clk);
        n_cmp++;
        if ({op_err, err_code, op_busy} !== {1'b1, 2'd3, 1'b1}) begin
            n_bad++; $display("FAIL wdog_fault: err=%b code=%0d busy=%b required 1/3/1", op_err, err_code, op_busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({op_err, err_code, op_busy, cmd_start, seq_cmd_done} !== {1'b0, 2'd3, 1'b1, 1'b0, 3'b000}) begin
            n_bad++; $display("FAIL wdog_hold: err=%b code=%0d busy=%b start=%b required 0/3/1/0", op_err, err_code, op_busy, cmd_start);
        end
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        n_cmp++;
        if (op_busy !== 1'b0) begin n_bad++; $display("FAIL wdog_clear: busy=%b required 0", op_busy); end
        resp_en = 1'b1;
    endtask

    task automatic test_done_wins();
        resp_en = 1'b0;
        start_op(2'd0);
        seq_cmd_start = 3'b001;
        @(negedge clk); seq_cmd_start = 3'b000;
        repeat (15) @(negedge clk);
        man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        n_cmp++;
        if ({op_err, op_busy} !== 2'b01) begin n_bad++; $display("FAIL done_wins_edge: err=%b busy=%b required 0/1", op_err, op_busy); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({op_err, err_code, op_busy} !== {1'b0, 2'd3, 1'b1}) begin
            n_bad++; $display("FAIL done_wins_idle_run: err=%b code=%0d busy=%b required 0/3/1", op_err, err_code, op_busy);
        end
        seq_done = 3'b001;
        @(negedge clk); seq_done = 3'b000;
        n_cmp++;
        if ({op_done, op_count} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL done_wins_finish: done=%b count=%0d required 1/1", op_done, op_count); end
        resp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_non_owner();
        start_op(2'd2);
        n_cmp++;
        if (seq_start !== 3'b100) begin n_bad++; $display("FAIL decaps_seq_start: seq_start=%b required 100", seq_start); end
        for (int k = 0; k < 6; k++) begin
            seq_cmd_start = k[0] ? 3'b011 : 3'b000;
            seq_done      = k[0] ? 3'b011 : 3'b000;
            man_done      = (k % 3 != 0);
            @(negedge clk);
            n_cmp++;
            if ({cmd_start, op_busy, seq_cmd_done} !== {1'b0, 1'b1, (man_done ? 3'b100 : 3'b000)}) begin
                n_bad++; $display("FAIL non_owner_%0d: start=%b busy=%b seq_cmd_done=%b required 0/1/%b",
                                  k, cmd_start, op_busy, seq_cmd_done, (man_done ? 3'b100 : 3'b000));
            end
        end
        seq_cmd_start = '0; man_done = 1'b0; seq_done = 3'b100;
        @(negedge clk); seq_done = 3'b000;
        n_cmp++;
        if ({op_done, op_count} !== {1'b1, 8'd0}) begin n_bad++; $display("FAIL decaps_done: done=%b count=%0d required 1/0", op_done, op_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int d0;
        start_op(2'd1);
        seq_cmd_start = 3'b010;
        @(negedge clk); seq_cmd_start = 3'b000;
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({op_busy, op_done, op_err, err_code, op_count, seq_start, seq_cmd_done, cmd_op,
             cmd_slot_a, cmd_slot_b, cmd_param, cmd_start} !== 38'd0) begin
            n_bad++; $display("FAIL reset_mid: busy=%b start=%b count=%0d code=%0d required all 0", op_busy, cmd_start, op_count, err_code);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({op_busy, done_cnt - d0} !== {1'b0, 32'd0}) begin
            n_bad++; $display("FAIL reset_mid_nodone: busy=%b pulses=%0d required 0/0", op_busy, done_cnt - d0);
        end
        start_op(2'd0);
        n_cmp++;
        if ({seq_start, op_busy} !== 4'b0011) begin n_bad++; $display("FAIL reset_restart: seq_start=%b busy=%b required 001/1", seq_start, op_busy); end
        seq_done = 3'b001;
        @(negedge clk); seq_done = 3'b000;
        n_cmp++;
        if (op_done !== 1'b1) begin n_bad++; $display("FAIL reset_restart_done: done=%b required 1", op_done); end
    endtask

    initial begin
        test_reset();
        test_keygen();
        test_bad_sel();
        test_busy_start();
        test_watchdog();
        test_done_wins();
        test_non_owner();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kem_op_sched.md
KEM_OP_SCHED -- requirements
Module: kem_op_sched

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 20000, meaning max cycles one forwarded micro-op may stay outstanding before fault.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- op_start  in  1  host pulse, begin operation
- op_sel  in  2  0=keygen, 1=encaps, 2=decaps, 3=invalid
- clear  in  1  leave FAULT
- op_busy  out  1  high when state != IDLE
- op_done  out  1  one-cycle completion pulse
- op_err  out  1  one-cycle error pulse
- err_code  out  2  1=bad op_sel, 2=start while busy, 3=watchdog; held until next op_err
- op_count  out  8  micro-ops forwarded in current/last operation, saturating
- seq_start  out  3  one-hot sequencer start pulse
- seq_done  in  3  sequencer done pulses
- seq_cmd_op  in  12  per-sequencer opcode, seq i at bits [4i+3:4i]
- seq_cmd_slot_a  in  15  per-sequencer slot_a, 5 bits each
- seq_cmd_slot_b  in  15  per-sequencer slot_b, 5 bits each
- seq_cmd_param  in  12  per-sequencer param, 4 bits each
- seq_cmd_start  in  3  per-sequencer command strobes
- seq_cmd_done  out  3  per-sequencer command done
- cmd_op / cmd_slot_a / cmd_slot_b / cmd_param  out  4/5/5/4  registered command to kyber_top
- cmd_start  out  1  registered command strobe to kyber_top
- cmd_done  in  1  command completion from kyber_top

Function
REQ-003 SHALL implement states IDLE, RUN, DONE, FAULT; 2-bit owner register selects active sequencer.
REQ-004 IDLE + op_start + op_sel<3: SHALL latch owner=op_sel, clear op_count, drive seq_start[owner]=1 for exactly the next cycle, enter RUN.
REQ-005 IDLE + op_start + op_sel==3: SHALL pulse op_err with err_code=1 next cycle, remain IDLE, no seq_start.
REQ-006 op_start in RUN, DONE or FAULT: SHALL be ignored except op_err pulse, err_code=2; owner and state unchanged.
REQ-007 RUN: every cycle, cmd_op/slot_a/slot_b/param SHALL register the owner's fields, and cmd_start SHALL register seq_cmd_start[owner]; latency exactly 1 cycle.
REQ-008 seq_cmd_done[owner] SHALL equal cmd_done combinationally in RUN; all other seq_cmd_done bits, and all bits outside RUN, SHALL be 0.
REQ-009 seq_cmd_start from non-owners SHALL be ignored; cmd_start SHALL be 0 outside RUN.
REQ-010 Each forwarded cmd_start SHALL set pending flag, reset watchdog counter to 0, increment op_count (saturate at 255).
REQ-011 cmd_done SHALL clear pending; cmd_done with pending=0 SHALL be ignored apart from REQ-008.
REQ-012 Watchdog SHALL increment each RUN cycle while pending=1; on reaching WDOG_CYCLES SHALL enter FAULT, pulse op_err, err_code=3.
REQ-013 Same-cycle cmd_done and watchdog expiry: cmd_done SHALL win (no fault).
REQ-014 seq_done[owner] in RUN SHALL move to DONE; seq_done from non-owners ignored.
REQ-015 DONE SHALL last one cycle, pulse op_done, return to IDLE; op_count held until next accepted op_start.
REQ-016 FAULT: op_busy=1, cmd_start=0; clear SHALL return to IDLE next cycle; clear in other states ignored.
REQ-017 op_done and op_err SHALL never be high longer than one cycle per event.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, owner=0, pending=0, watchdog=0 and every output (including cmd_* and seq_start) to 0; mid-operation reset aborts without op_done.

Verification
REQ-019 op_start, op_sel=0; keygen model issues 69 commands, each done after 3 cycles -> seq_start=3'b001 one cycle, each cmd_start 1 cycle after seq strobe, op_done once, op_count=69.
REQ-020 op_sel=3 in IDLE -> op_err one cycle, err_code=1, op_busy stays 0.
REQ-021 op_start during encaps RUN -> op_err, err_code=2, owner remains 1, encaps completes normally.
REQ-022 WDOG_CYCLES=16, cmd_done withheld -> FAULT after 16 pending cycles, err_code=3, op_busy=1; clear -> IDLE next cycle.
REQ-023 decaps running, keygen/encaps models toggle seq_cmd_start and seq_done -> no forwarded commands from them, their seq_cmd_done stay 0.
REQ-024 rst_n asserted mid-RUN -> all outputs 0 immediately, no op_done; new op_start after release accepted.
